// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// with *W word mode, valid/ready handshakes, flush, and RISC-V divide special cases.
module muldiv_unit #(
   parameter int XLEN      = 64,
   parameter int TAG_W     = 5,
   parameter int EARLY_OUT = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       op_i,
   input  logic             word_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_o
);
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         op_q;
   logic               word_q, neg_a_q, neg_b_q, special_q;
   logic [TAG_W-1:0]   tag_q;
   logic [XLEN-1:0]    hi_q, lo_q, opd_q, spec_q;

   logic               accept, word_eff, a_sgn, b_sgn, neg_a, neg_b;
   logic               div_zero, div_ovf, special, last_step, div_ge;
   logic [XLEN-1:0]    a_eff, b_eff, a_mag, b_mag, min_neg, spec_res;
   logic [XLEN-1:0]    hi_n, lo_n, quo, rem, done_res;
   logic [XLEN:0]      mul_sum, rem_sh;
   logic [2*XLEN-1:0]  prod;

   function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
      logic [XLEN-1:0] r;
      r = XLEN'(v);
      if (sgn) r = XLEN'($signed(v));
      return r;
   endfunction

   assign ready_o   = (state == IDLE);
   assign valid_o   = (state == DONE);
   assign accept    = (state == IDLE) & valid_i & ~flush_i;
   assign last_step = (cnt_q == (word_q ? CNT_W'(31) : CNT_W'(XLEN-1)));

   // Request decode: effective operands, magnitudes and the divide special cases.
   always_comb begin
      // NOTE: every variable gets a value before any branch so no latch is inferred.
      spec_res = '0;
      word_eff = word_i & (op_i[2] | (op_i[1:0] == 2'd0));
      a_sgn    = (op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6);
      b_sgn    = (op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6);
      a_eff    = word_eff ? ext32(a_i[31:0], a_sgn) : a_i;
      b_eff    = word_eff ? ext32(b_i[31:0], b_sgn) : b_i;
      neg_a    = a_sgn & a_eff[XLEN-1];
      neg_b    = b_sgn & b_eff[XLEN-1];
      a_mag    = neg_a ? -a_eff : a_eff;
      b_mag    = neg_b ? -b_eff : b_eff;
      min_neg  = word_eff ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = op_i[2] & (b_eff == '0);
      div_ovf  = op_i[2] & ~op_i[0] & (a_eff == min_neg) & (b_eff == '1);
      special  = div_zero | div_ovf;
      if (div_zero)     spec_res = op_i[1] ? a_eff : '1;
      else if (div_ovf) spec_res = op_i[1] ? '0 : a_eff;
      if (word_eff)     spec_res = ext32(spec_res[31:0], 1'b1);
   end

   // One radix-2 step, plus the sign fix-up of the value it produces.
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
      rem_sh  = {hi_q, lo_q[XLEN-1]};
      div_ge  = (rem_sh >= {1'b0, opd_q});
      if (op_q[2]) begin
         hi_n = div_ge ? XLEN'(rem_sh - {1'b0, opd_q}) : rem_sh[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], div_ge};
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      prod = {hi_n, lo_n} >> (word_q ? XLEN-32 : 0);
      if (neg_a_q ^ neg_b_q) prod = -prod;
      quo = (neg_a_q ^ neg_b_q) ? -lo_n : lo_n;
      rem = neg_a_q ? -hi_n : hi_n;
      if (special_q)               done_res = spec_q;
      else if (op_q[2])            done_res = op_q[1] ? rem : quo;
      else if (op_q[1:0] == 2'd0)  done_res = prod[XLEN-1:0];
      else                         done_res = prod[2*XLEN-1:XLEN];
      if (word_q) done_res = ext32(done_res[31:0], 1'b1);
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         state    <= IDLE;
         cnt_q    <= '0;
         result_o <= '0;
         tag_o    <= '0;
      end else if (flush_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (valid_i) begin
               cnt_q <= '0;
               if ((EARLY_OUT != 0) && special) begin
                  state    <= DONE;
                  result_o <= spec_res;
                  tag_o    <= tag_i;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_step) begin
                  state    <= DONE;
                  result_o <= done_res;
                  tag_o    <= tag_q;
               end
            end
            DONE:    if (ready_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: working registers have no reset; accept always loads them before CALC reads them.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q      <= op_i;
         word_q    <= word_eff;
         tag_q     <= tag_i;
         neg_a_q   <= neg_a;
         neg_b_q   <= neg_b;
         special_q <= special;
         spec_q    <= spec_res;
         hi_q      <= '0;
         if (op_i[2]) begin
            lo_q  <= word_eff ? (a_mag << (XLEN-32)) : a_mag;
            opd_q <= b_mag;
         end else begin
            lo_q  <= b_mag;
            opd_q <= a_mag;
         end
      end else if (state == CALC) begin
         hi_q <= hi_n;
         lo_q <= lo_n;
      end
   end
endmodule
